// File: rtl/capture_ring_ram.sv
// rtl/capture_ring_ram.sv - armed/triggered capture ring buffer with post-trigger count and indexed readout
module capture_ring_ram #(
  parameter int RAM_WIDTH = 32,
  parameter int RAM_DEPTH = 1024,
  parameter int OUT_REG   = 1,
  localparam int AW = $clog2(RAM_DEPTH)
) (
  input  logic                 clk,
  input  logic                 i_reset,
  input  logic [RAM_WIDTH-1:0] i_data,
  input  logic                 i_data_valid,
  input  logic                 i_arm,
  input  logic                 i_trigger,
  input  logic [AW-1:0]        i_post_count,
  input  logic                 i_rd_req,
  input  logic [AW-1:0]        i_rd_addr,
  output logic [RAM_WIDTH-1:0] o_rd_data,
  output logic                 o_rd_valid,
  output logic [1:0]           o_state,
  output logic [AW-1:0]        o_trig_addr,
  output logic [AW:0]          o_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_POST  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [RAM_WIDTH-1:0] mem [RAM_DEPTH];

  logic [AW-1:0] wr_ptr;
  logic          wrapped;
  logic [AW-1:0] post_left;
  logic [AW-1:0] trig_addr;

  logic arm_take;
  logic wr_en;
  logic trig_take;
  logic post_dec;
  logic rd_take;

  logic [AW-1:0] rd_base;
  logic [AW-1:0] rd_phys;

  logic [RAM_WIDTH-1:0] rd1_data;
  logic                 rd1_valid;

  // State register
  always_ff @(posedge clk) begin
    if (i_reset) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // Next-state: arm from IDLE/DONE, trigger in ARMED, post countdown in POST
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (i_arm) state_nxt = S_ARMED;
      S_ARMED: if (i_data_valid && i_trigger)
                 state_nxt = (post_left == '0) ? S_DONE : S_POST;
      S_POST:  if (i_data_valid && post_left == AW'(1)) state_nxt = S_DONE;
      S_DONE:  if (i_arm) state_nxt = S_ARMED;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Per-state strobes; reset suppresses every action including RAM writes
  always_comb begin
    arm_take  = 1'b0;
    wr_en     = 1'b0;
    trig_take = 1'b0;
    post_dec  = 1'b0;
    rd_take   = 1'b0;
    if (!i_reset) begin
      case (state)
        S_IDLE:  arm_take = i_arm;
        S_ARMED: begin
          wr_en     = i_data_valid;
          trig_take = i_data_valid && i_trigger;
        end
        S_POST:  begin
          wr_en    = i_data_valid;
          post_dec = i_data_valid;
        end
        S_DONE:  begin
          arm_take = i_arm;
          rd_take  = i_rd_req;
        end
        default: ;
      endcase
    end
  end

  // Write pointer, wrap flag, post counter and trigger address
  always_ff @(posedge clk) begin
    if (i_reset) begin
      wr_ptr    <= '0;
      wrapped   <= 1'b0;
      post_left <= '0;
      trig_addr <= '0;
    end else if (arm_take) begin
      wr_ptr    <= '0;
      wrapped   <= 1'b0;
      post_left <= i_post_count;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (&wr_ptr) wrapped <= 1'b1;
      end
      if (trig_take) trig_addr <= wr_ptr;
      if (post_dec)  post_left <= post_left - 1'b1;
    end
  end

  // Sample storage; contents survive reset
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= i_data;
  end

  // Oldest sample sits at the write pointer once the ring has wrapped
  assign rd_base = wrapped ? wr_ptr : '0;
  assign rd_phys = rd_base + i_rd_addr;

  // First read stage: RAM read register, updated only on accepted requests
  always_ff @(posedge clk) begin
    if (i_reset) begin
      rd1_data  <= '0;
      rd1_valid <= 1'b0;
    end else begin
      rd1_valid <= rd_take;
      if (rd_take) rd1_data <= mem[rd_phys];
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [RAM_WIDTH-1:0] q_data;
      logic                 q_valid;
      // Optional output register; holds data between valid beats
      always_ff @(posedge clk) begin
        if (i_reset) begin
          q_data  <= '0;
          q_valid <= 1'b0;
        end else begin
          q_valid <= rd1_valid;
          if (rd1_valid) q_data <= rd1_data;
        end
      end
      assign o_rd_data  = q_data;
      assign o_rd_valid = q_valid;
    end else begin : g_no_out_reg
      assign o_rd_data  = rd1_data;
      assign o_rd_valid = rd1_valid;
    end
  endgenerate

  assign o_state     = state;
  assign o_trig_addr = trig_addr;
  assign o_count     = wrapped ? (AW+1)'(RAM_DEPTH) : {1'b0, wr_ptr};

endmodule

// File: tb/tb_capture_ring_ram.sv
// tb/tb_capture_ring_ram.sv - randomized and directed bench for capture_ring_ram against a sample-stream model
module tb_capture_ring_ram;
  localparam int W  = 32;
  localparam int D  = 16;
  localparam int AW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic [W-1:0]  d   = '0;
  logic          dv  = 1'b0;
  logic          arm = 1'b0;
  logic          trg = 1'b0;
  logic [AW-1:0] pc  = '0;
  logic          rq  = 1'b0;
  logic [AW-1:0] ra  = '0;

  logic [W-1:0]  da, db;
  logic          va, vb;
  logic [1:0]    st_a, st_b;
  logic [AW-1:0] tg_a, tg_b;
  logic [AW:0]   cn_a, cn_b;

  capture_ring_ram #(.RAM_WIDTH(W), .RAM_DEPTH(D), .OUT_REG(1)) u_a (
    .clk(clk), .i_reset(rst), .i_data(d), .i_data_valid(dv), .i_arm(arm),
    .i_trigger(trg), .i_post_count(pc), .i_rd_req(rq), .i_rd_addr(ra),
    .o_rd_data(da), .o_rd_valid(va), .o_state(st_a), .o_trig_addr(tg_a), .o_count(cn_a)
  );

  capture_ring_ram #(.RAM_WIDTH(W), .RAM_DEPTH(D), .OUT_REG(0)) u_b (
    .clk(clk), .i_reset(rst), .i_data(d), .i_data_valid(dv), .i_arm(arm),
    .i_trigger(trg), .i_post_count(pc), .i_rd_req(rq), .i_rd_addr(ra),
    .o_rd_data(db), .o_rd_valid(vb), .o_state(st_b), .o_trig_addr(tg_b), .o_count(cn_b)
  );

  int checks = 0;
  int errors = 0;

  // Model: the captured samples, oldest first, plus counters kept in plain integers
  int           m_state = 0;
  logic [W-1:0] m_stream[$];
  int           m_nwr   = 0;
  int           m_post  = 0;
  int           m_trig  = 0;
  int           cyc     = 0;

  typedef struct {
    int           due;
    logic [W-1:0] d;
  } rd_t;
  rd_t qa[$];
  rd_t qb[$];

  logic         exp_va = 1'b0, exp_vb = 1'b0;
  logic [W-1:0] exp_da = '0, exp_db = '0;

  function automatic int m_count();
    return (m_nwr >= D) ? D : m_nwr;
  endfunction

  task automatic m_push(input logic [W-1:0] x);
    m_stream.push_back(x);
    m_nwr++;
    if (m_stream.size() > D) void'(m_stream.pop_front());
  endtask

  // Advance model with the current inputs, then clock once and settle
  task automatic tick();
    rd_t e;
    if (rst) begin
      m_state = 0; m_stream.delete(); m_nwr = 0; m_trig = 0; m_post = 0;
      qa.delete(); qb.delete();
    end else begin
      case (m_state)
        0, 3: begin
          if (m_state == 3 && rq) begin
            e.d   = (int'(ra) < m_stream.size()) ? m_stream[ra] : '0;
            e.due = cyc + 2; qa.push_back(e);
            e.due = cyc + 1; qb.push_back(e);
          end
          if (arm) begin
            m_state = 1; m_stream.delete(); m_nwr = 0; m_post = int'(pc);
          end
        end
        1: if (dv) begin
          m_push(d);
          if (trg) begin
            m_trig  = (m_nwr - 1) % D;
            m_state = (m_post == 0) ? 3 : 2;
          end
        end
        2: if (dv) begin
          m_push(d);
          m_post--;
          if (m_post == 0) m_state = 3;
        end
        default: ;
      endcase
    end
    @(posedge clk); #1;
    cyc++;
    if (rst) begin
      exp_va = 1'b0; exp_vb = 1'b0; exp_da = '0; exp_db = '0;
    end else begin
      exp_va = 1'b0;
      exp_vb = 1'b0;
      if (qa.size() > 0 && qa[0].due == cyc) begin e = qa.pop_front(); exp_va = 1'b1; exp_da = e.d; end
      if (qb.size() > 0 && qb[0].due == cyc) begin e = qb.pop_front(); exp_vb = 1'b1; exp_db = e.d; end
    end
  endtask

  task automatic idle_inputs();
    arm = 1'b0; trg = 1'b0; dv = 1'b0; rq = 1'b0; d = '0; ra = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; idle_inputs();
    tick(); tick();
    rst = 1'b0;
    checks++; if (st_a !== 2'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", st_a); end
    checks++; if (cn_a !== 5'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", cn_a); end
    checks++; if (tg_a !== 4'd0) begin errors++; $display("FAIL reset_trig got=%0d exp=0", tg_a); end
    checks++; if (va !== 1'b0 || vb !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b%b exp=00", va, vb); end
    checks++; if (da !== '0 || db !== '0) begin errors++; $display("FAIL reset_data got=%0h/%0h exp=0", da, db); end
  endtask

  task automatic test_basic();
    int na = 0;
    arm = 1'b1; pc = 4'd3; tick(); arm = 1'b0;
    checks++; if (st_a !== 2'd1) begin errors++; $display("FAIL basic_armed got=%0d exp=1", st_a); end
    for (int i = 0; i < 6; i++) begin
      dv = 1'b1; d = W'(i); trg = (i == 2); tick();
      if (i == 2) begin
        checks++; if (st_a !== 2'd2) begin errors++; $display("FAIL basic_post got=%0d exp=2", st_a); end
      end
      if (i == 4) begin
        checks++; if (st_a !== 2'd2) begin errors++; $display("FAIL basic_still_post got=%0d exp=2", st_a); end
      end
    end
    idle_inputs();
    checks++; if (st_a !== 2'd3) begin errors++; $display("FAIL basic_done got=%0d exp=3", st_a); end
    checks++; if (tg_a !== 4'd2) begin errors++; $display("FAIL basic_trig got=%0d exp=2", tg_a); end
    checks++; if (cn_a !== 5'd6) begin errors++; $display("FAIL basic_count got=%0d exp=6", cn_a); end
    for (int i = 0; i < 9; i++) begin
      rq = (i < 6); ra = AW'(i); tick();
      if (va) na++;
      if (i >= 1 && i <= 6) begin
        checks++; if (va !== 1'b1 || da !== W'(i - 1)) begin errors++; $display("FAIL basic_read_a%0d got=%b/%0h exp=1/%0h", i - 1, va, da, i - 1); end
      end
      checks++; if (vb !== exp_vb || db !== exp_db) begin errors++; $display("FAIL basic_read_b got=%b/%0h exp=%b/%0h", vb, db, exp_vb, exp_db); end
    end
    checks++; if (na !== 6) begin errors++; $display("FAIL basic_read_beats got=%0d exp=6", na); end
    idle_inputs();
  endtask

  task automatic test_wrap();
    arm = 1'b1; pc = 4'd2; tick(); arm = 1'b0;
    for (int i = 0; i < 20; i++) begin
      dv = 1'b1; d = W'(i); trg = (i == 17); tick();
    end
    idle_inputs();
    checks++; if (st_a !== 2'd3) begin errors++; $display("FAIL wrap_done got=%0d exp=3", st_a); end
    checks++; if (cn_a !== 5'd16) begin errors++; $display("FAIL wrap_count got=%0d exp=16", cn_a); end
    checks++; if (tg_a !== 4'd1) begin errors++; $display("FAIL wrap_trig got=%0d exp=1", tg_a); end
    rq = 1'b1; ra = 4'd0; tick();
    checks++; if (vb !== 1'b1 || db !== 32'd4) begin errors++; $display("FAIL wrap_oldest_b got=%b/%0d exp=1/4", vb, db); end
    ra = 4'd15; tick();
    checks++; if (va !== 1'b1 || da !== 32'd4) begin errors++; $display("FAIL wrap_oldest_a got=%b/%0d exp=1/4", va, da); end
    rq = 1'b0; tick();
    checks++; if (va !== 1'b1 || da !== 32'd19) begin errors++; $display("FAIL wrap_newest_a got=%b/%0d exp=1/19", va, da); end
    checks++; if (vb !== 1'b0 || db !== 32'd19) begin errors++; $display("FAIL wrap_hold_b got=%b/%0d exp=0/19", vb, db); end
    tick();
  endtask

  task automatic test_post_zero();
    arm = 1'b1; pc = 4'd0; tick(); arm = 1'b0;
    dv = 1'b1; trg = 1'b1; d = 32'hA5; tick();
    idle_inputs();
    checks++; if (st_a !== 2'd3) begin errors++; $display("FAIL pz_done got=%0d exp=3", st_a); end
    checks++; if (cn_a !== 5'd1) begin errors++; $display("FAIL pz_count got=%0d exp=1", cn_a); end
    checks++; if (tg_a !== 4'd0) begin errors++; $display("FAIL pz_trig got=%0d exp=0", tg_a); end
    rq = 1'b1; ra = 4'd0; tick(); rq = 1'b0;
    checks++; if (vb !== 1'b1 || db !== 32'hA5) begin errors++; $display("FAIL pz_read_b got=%b/%0h exp=1/a5", vb, db); end
    tick();
    checks++; if (va !== 1'b1 || da !== 32'hA5) begin errors++; $display("FAIL pz_read_a got=%b/%0h exp=1/a5", va, da); end
  endtask

  task automatic test_ignore();
    arm = 1'b1; pc = 4'd5; tick(); arm = 1'b0;
    trg = 1'b1; dv = 1'b0; tick();
    checks++; if (st_a !== 2'd1 || cn_a !== 5'd0) begin errors++; $display("FAIL ign_trig_novalid got=%0d/%0d exp=1/0", st_a, cn_a); end
    rq = 1'b1; trg = 1'b0; dv = 1'b1; d = 32'd7; tick(); rq = 1'b0; tick();
    checks++; if (va !== 1'b0 || vb !== 1'b0) begin errors++; $display("FAIL ign_read_armed got=%b%b exp=00", va, vb); end
    arm = 1'b1; pc = 4'd0; d = 32'd8; tick(); arm = 1'b0;
    checks++; if (st_a !== 2'd1 || cn_a !== 5'(m_count())) begin errors++; $display("FAIL ign_arm_armed got=%0d/%0d exp=1/%0d", st_a, cn_a, m_count()); end
    trg = 1'b1; tick(); trg = 1'b0;
    for (int i = 0; i < 5; i++) begin d = W'(100 + i); tick(); end
    dv = 1'b0;
    checks++; if (st_a !== 2'd3 || tg_a !== 4'd3) begin errors++; $display("FAIL ign_done got=%0d/%0d exp=3/3", st_a, tg_a); end
    arm = 1'b1; trg = 1'b1; dv = 1'b1; pc = 4'd4; tick(); idle_inputs();
    checks++; if (st_a !== 2'd1 || cn_a !== 5'd0) begin errors++; $display("FAIL ign_rearm got=%0d/%0d exp=1/0", st_a, cn_a); end
    checks++; if (tg_a !== 4'd3) begin errors++; $display("FAIL ign_rearm_trig got=%0d exp=3", tg_a); end
  endtask

  task automatic test_back_to_back_reset();
    int nb = 0;
    rst = 1'b1; tick(); rst = 1'b0;
    arm = 1'b1; pc = 4'd1; tick(); arm = 1'b0;
    for (int i = 0; i < 6; i++) begin dv = 1'b1; d = W'(10 + i); trg = (i == 4); tick(); end
    idle_inputs();
    for (int i = 0; i < 5; i++) begin
      rq = (i < 3); ra = AW'(i + 1); tick();
      if (vb) nb++;
      checks++; if (vb !== exp_vb || db !== exp_db) begin errors++; $display("FAIL b2b_read_b got=%b/%0h exp=%b/%0h", vb, db, exp_vb, exp_db); end
      checks++; if (va !== exp_va || da !== exp_da) begin errors++; $display("FAIL b2b_read_a got=%b/%0h exp=%b/%0h", va, da, exp_va, exp_da); end
      if (i < 3) begin
        checks++; if (vb !== 1'b1 || db !== W'(11 + i)) begin errors++; $display("FAIL b2b_lat1_%0d got=%b/%0d exp=1/%0d", i, vb, db, 11 + i); end
      end
    end
    checks++; if (nb !== 3) begin errors++; $display("FAIL b2b_beats got=%0d exp=3", nb); end
    rq = 1'b1; ra = 4'd0; tick(); rq = 1'b0;
    arm = 1'b1; pc = 4'd3; tick(); arm = 1'b0;
    checks++; if (va !== 1'b1 || da !== 32'd10 || st_a !== 2'd1) begin errors++; $display("FAIL inflight_rearm got=%b/%0d/%0d exp=1/10/1", va, da, st_a); end
    dv = 1'b1; d = 32'd50; tick();
    trg = 1'b1; d = 32'd51; tick(); trg = 1'b0;
    checks++; if (st_a !== 2'd2 || tg_a !== 4'd1) begin errors++; $display("FAIL b2b_post got=%0d/%0d exp=2/1", st_a, tg_a); end
    rst = 1'b1; tick(); rst = 1'b0; idle_inputs();
    checks++; if (st_a !== 2'd0 || st_b !== 2'd0) begin errors++; $display("FAIL midreset_state got=%0d/%0d exp=0", st_a, st_b); end
    checks++; if (cn_a !== 5'd0 || tg_a !== 4'd0) begin errors++; $display("FAIL midreset_cnt_trig got=%0d/%0d exp=0/0", cn_a, tg_a); end
    checks++; if (va !== 1'b0 || vb !== 1'b0 || da !== '0 || db !== '0) begin errors++; $display("FAIL midreset_read got=%b%b/%0h/%0h exp=0", va, vb, da, db); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom % 300) == 0;
      arm = ($urandom % 25) == 0;
      dv  = ($urandom % 10) < 7;
      trg = ($urandom % 12) == 0;
      d   = $urandom;
      pc  = AW'($urandom % 6);
      rq  = (m_state == 3) ? ($urandom % 2 == 0) : ($urandom % 4 == 0);
      ra  = (m_stream.size() > 0) ? AW'($urandom % m_stream.size()) : '0;
      tick();
      checks++; if (st_a !== 2'(m_state) || st_b !== 2'(m_state)) begin errors++; $display("FAIL rnd_state cyc=%0d got=%0d/%0d exp=%0d", cyc, st_a, st_b, m_state); end
      checks++; if (cn_a !== 5'(m_count()) || cn_b !== 5'(m_count())) begin errors++; $display("FAIL rnd_count cyc=%0d got=%0d/%0d exp=%0d", cyc, cn_a, cn_b, m_count()); end
      checks++; if (tg_a !== 4'(m_trig) || tg_b !== 4'(m_trig)) begin errors++; $display("FAIL rnd_trig cyc=%0d got=%0d/%0d exp=%0d", cyc, tg_a, tg_b, m_trig); end
      checks++; if (va !== exp_va || da !== exp_da) begin errors++; $display("FAIL rnd_read_a cyc=%0d got=%b/%0h exp=%b/%0h", cyc, va, da, exp_va, exp_da); end
      checks++; if (vb !== exp_vb || db !== exp_db) begin errors++; $display("FAIL rnd_read_b cyc=%0d got=%b/%0h exp=%b/%0h", cyc, vb, db, exp_vb, exp_db); end
    end
    rst = 1'b0; idle_inputs();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_post_zero();
    test_ignore();
    test_back_to_back_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
